envelope_ramp_counter: RTL and testbench

//  Consumer end of the exponential incrementer link: turns inc_control pulse trains into an envelope level.

---
 rtl/envelope_ramp_counter_pkg.sv | 15 +
 rtl/envelope_ramp_counter_gate_edge_detect.sv | 21 ++
 rtl/envelope_ramp_counter.sv | 102 ++++++++++
 tb/tb_envelope_ramp_counter.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/envelope_ramp_counter_pkg.sv
// envelope_ramp_counter_pkg: envelope state encodings and shared defaults
package envelope_ramp_counter_pkg;

    typedef enum logic [1:0] {
        ENV_IDLE    = 2'd0,
        ENV_ATTACK  = 2'd1,
        ENV_HOLD    = 2'd2,
        ENV_RELEASE = 2'd3
    } envState_t;

    // Matches the incrementer controller's 3-cycle load time
    localparam int DEFAULT_SETTLE_CYCLES = 3;
    localparam int DEFAULT_WIDTH         = 10;

endpackage

// File: rtl/envelope_ramp_counter_gate_edge_detect.sv
// envelope_ramp_counter_gate_edge_detect: rise/fall detection on the note gate
module envelope_ramp_counter_gate_edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic gate,
    output logic rise,
    output logic fall
);

    logic gateQ;

    // Remember gate from the previous edge; clearing it in reset makes a held gate count as a rise
    always_ff @(posedge clk) begin
        if (!reset) gateQ <= 1'b0;
        else        gateQ <= gate;
    end

    assign rise = gate & ~gateQ;
    assign fall = ~gate & gateQ;

endmodule

// File: rtl/envelope_ramp_counter.sv
// envelope_ramp_counter: gate-driven attack/hold/release envelope fed by incrementer pulses
module envelope_ramp_counter
    import envelope_ramp_counter_pkg::*;
#(
    parameter int WIDTH         = DEFAULT_WIDTH,
    parameter int SETTLE_CYCLES = DEFAULT_SETTLE_CYCLES
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             gate,
    input  logic [WIDTH-1:0] max_out,
    input  logic             inc_attack,
    input  logic             inc_release,
    output logic             start_attack,
    output logic             start_release,
    output logic [WIDTH-1:0] level,
    output logic [1:0]       env_state,
    output logic             done
);

    localparam int SW = $clog2(SETTLE_CYCLES + 2);

    envState_t        state, stateNext;
    logic [WIDTH-1:0] levelNext;
    logic [SW-1:0]    settle, settleNext;
    logic             startAttackNext, startReleaseNext, doneNext;
    logic             rise, fall;

    envelope_ramp_counter_gate_edge_detect edgeDetect (
        .clk   (clk),
        .reset (reset),
        .gate  (gate),
        .rise  (rise),
        .fall  (fall)
    );

    // State, level, settle counter and all outputs are registered
    always_ff @(posedge clk) begin
        if (!reset) begin
            state         <= ENV_IDLE;
            level         <= '0;
            settle        <= '0;
            start_attack  <= 1'b0;
            start_release <= 1'b0;
            done          <= 1'b0;
        end else begin
            state         <= stateNext;
            level         <= levelNext;
            settle        <= settleNext;
            start_attack  <= startAttackNext;
            start_release <= startReleaseNext;
            done          <= doneNext;
        end
    end

    // Gate edges take priority; otherwise ramp level once the controller has reloaded
    always_comb begin
        stateNext        = state;
        levelNext        = level;
        settleNext       = (settle != '0) ? settle - 1'b1 : '0;
        startAttackNext  = 1'b0;
        startReleaseNext = 1'b0;
        doneNext         = 1'b0;
        if (rise) begin
            stateNext       = ENV_ATTACK;
            startAttackNext = 1'b1;
            settleNext      = SW'(SETTLE_CYCLES);
        end else if (fall && (state == ENV_ATTACK || state == ENV_HOLD)) begin
            stateNext        = ENV_RELEASE;
            startReleaseNext = 1'b1;
            settleNext       = SW'(SETTLE_CYCLES);
        end else begin
            case (state)
                ENV_IDLE: levelNext = '0;
                ENV_ATTACK: begin
                    if (settle == '0) begin
                        if (level >= max_out) begin
                            levelNext = max_out;
                            stateNext = ENV_HOLD;
                        end else if (inc_attack) begin
                            levelNext = level + 1'b1;
                        end
                    end
                end
                ENV_HOLD: levelNext = (level > max_out) ? max_out : level;
                ENV_RELEASE: begin
                    if (settle == '0 && (level == '0 || (inc_release && level == WIDTH'(1)))) begin
                        levelNext = '0;
                        stateNext = ENV_IDLE;
                        doneNext  = 1'b1;
                    end else if (settle == '0 && inc_release) begin
                        levelNext = level - 1'b1;
                    end
                end
                default: stateNext = ENV_IDLE;
            endcase
        end
    end

    assign env_state = state;

endmodule

// File: tb/tb_envelope_ramp_counter.sv
// tb_envelope_ramp_counter: randomized and scripted checks against an envelope reference model
module tb_envelope_ramp_counter;

    localparam int WIDTH  = 10;
    localparam int SETTLE = 3;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             gate = 1'b0;
    logic [WIDTH-1:0] maxOut = '0;
    logic             incAttack = 1'b0;
    logic             incRelease = 1'b0;
    logic             startAttack, startRelease, done;
    logic [WIDTH-1:0] level;
    logic [1:0]       envState;

    int checks = 0;
    int errors = 0;

    // Reference model: envelope phase as an integer, level as a plain number
    int mGateQ = 0, mLevel = 0, mPhase = 0, mSettle = 0, mSA = 0, mSR = 0, mDone = 0;

    envelope_ramp_counter #(.WIDTH(WIDTH), .SETTLE_CYCLES(SETTLE)) dut (
        .clk           (clk),
        .reset         (reset),
        .gate          (gate),
        .max_out       (maxOut),
        .inc_attack    (incAttack),
        .inc_release   (incRelease),
        .start_attack  (startAttack),
        .start_release (startRelease),
        .level         (level),
        .env_state     (envState),
        .done          (done)
    );

    always #5 clk = ~clk;

    wire [WIDTH+4:0] dutOut = {level, envState, startAttack, startRelease, done};

    function automatic logic [WIDTH+4:0] modelOut();
        return {WIDTH'(mLevel), 2'(mPhase), mSA[0], mSR[0], mDone[0]};
    endfunction

    // Advance one clock: the model applies the envelope rules to the inputs seen at this edge
    task automatic cyc();
        int rise, fall, pulseOk, mx;
        @(posedge clk);
        mx = int'(maxOut);
        if (!reset) begin
            mGateQ = 0; mLevel = 0; mPhase = 0; mSettle = 0; mSA = 0; mSR = 0; mDone = 0;
        end else begin
            rise = (gate && mGateQ == 0) ? 1 : 0;
            fall = (!gate && mGateQ == 1) ? 1 : 0;
            mGateQ = gate ? 1 : 0;
            pulseOk = (mSettle == 0) ? 1 : 0;
            mSettle = (mSettle > 0) ? mSettle - 1 : 0;
            mSA = 0; mSR = 0; mDone = 0;
            if (rise == 1) begin
                mPhase = 1; mSA = 1; mSettle = SETTLE;
            end else if (fall == 1 && (mPhase == 1 || mPhase == 2)) begin
                mPhase = 3; mSR = 1; mSettle = SETTLE;
            end else if (mPhase == 0) begin
                mLevel = 0;
            end else if (mPhase == 1 && pulseOk == 1) begin
                if (mLevel >= mx) begin mLevel = mx; mPhase = 2; end
                else if (incAttack) mLevel = mLevel + 1;
            end else if (mPhase == 2) begin
                if (mLevel > mx) mLevel = mx;
            end else if (mPhase == 3 && pulseOk == 1) begin
                if (mLevel == 0) begin mPhase = 0; mDone = 1; end
                else if (incRelease) begin
                    mLevel = mLevel - 1;
                    if (mLevel == 0) begin mPhase = 0; mDone = 1; end
                end
            end
        end
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; gate = 1'b0; maxOut = 10'd5; incAttack = 1'b0; incRelease = 1'b0;
        cyc(); cyc();
        checks++;
        if (dutOut !== '0) begin errors++; $display("FAIL reset_state got %h want 0", dutOut); end
        reset = 1'b1;
        for (int i = 0; i < 20; i++) begin
            incAttack = 1'($urandom); incRelease = 1'($urandom);
            cyc();
            checks++;
            if (dutOut !== '0) begin errors++; $display("FAIL idle_quiet cycle %0d got %h want 0", i, dutOut); end
        end
        incAttack = 1'b0; incRelease = 1'b0;
    endtask

    task automatic test_attack();
        maxOut = 10'd4; gate = 1'b1;
        cyc();
        checks++;
        if ({startAttack, envState} !== 3'b101) begin errors++; $display("FAIL attack_start got %b want 101", {startAttack, envState}); end
        incAttack = 1'b1;
        for (int i = 0; i < SETTLE; i++) begin
            cyc();
            checks++;
            if (level !== 10'd0 || startAttack !== 1'b0) begin errors++; $display("FAIL attack_settle got level %0d sa %b want 0 0", level, startAttack); end
        end
        for (int k = 1; k <= 4; k++) begin
            incAttack = 1'b0;
            for (int g = $urandom_range(0, 2); g > 0; g--) begin
                cyc();
                checks++;
                if (dutOut !== modelOut()) begin errors++; $display("FAIL attack_gap got %h want %h", dutOut, modelOut()); end
            end
            incAttack = 1'b1;
            cyc();
            checks++;
            if (level !== 10'(k) || envState !== 2'd1) begin errors++; $display("FAIL attack_step got %0d/%0d want %0d/1", level, envState, k); end
        end
        incAttack = 1'b0;
        cyc();
        checks++;
        if (level !== 10'd4 || envState !== 2'd2) begin errors++; $display("FAIL attack_hold got %0d/%0d want 4/2", level, envState); end
        incAttack = 1'b1;
        cyc();
        incAttack = 1'b0;
        checks++;
        if (level !== 10'd4 || envState !== 2'd2) begin errors++; $display("FAIL hold_saturate got %0d/%0d want 4/2", level, envState); end
    endtask

    task automatic test_release();
        gate = 1'b0;
        cyc();
        checks++;
        if ({startRelease, envState, level} !== {1'b1, 2'd3, 10'd4}) begin errors++; $display("FAIL release_start got %b/%0d/%0d want 1/3/4", startRelease, envState, level); end
        incRelease = 1'b1;
        for (int i = 0; i < SETTLE; i++) begin
            cyc();
            checks++;
            if (level !== 10'd4) begin errors++; $display("FAIL release_settle got %0d want 4", level); end
        end
        for (int k = 1; k <= 4; k++) begin
            incRelease = 1'b0;
            for (int g = $urandom_range(0, 2); g > 0; g--) begin
                cyc();
                checks++;
                if (dutOut !== modelOut()) begin errors++; $display("FAIL release_gap got %h want %h", dutOut, modelOut()); end
            end
            incRelease = 1'b1;
            cyc();
            checks++;
            if (level !== 10'(4 - k) || done !== (k == 4)) begin errors++; $display("FAIL release_step got %0d done %b want %0d", level, done, 4 - k); end
        end
        incRelease = 1'b0;
        checks++;
        if (envState !== 2'd0) begin errors++; $display("FAIL release_idle got %0d want 0", envState); end
        cyc();
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL done_single got %b want 0", done); end
    endtask

    task automatic test_retrigger();
        maxOut = 10'd6; gate = 1'b1;
        cyc();
        repeat (SETTLE) cyc();
        incAttack = 1'b1;
        repeat (3) cyc();
        incAttack = 1'b0;
        checks++;
        if (level !== 10'd3 || envState !== 2'd1) begin errors++; $display("FAIL retrig_climb got %0d/%0d want 3/1", level, envState); end
        gate = 1'b0;
        cyc();
        checks++;
        if ({startRelease, envState, level} !== {1'b1, 2'd3, 10'd3}) begin errors++; $display("FAIL retrig_release got %b/%0d/%0d want 1/3/3", startRelease, envState, level); end
        repeat (SETTLE) cyc();
        incRelease = 1'b1;
        repeat (2) cyc();
        incRelease = 1'b0;
        gate = 1'b1;
        cyc();
        checks++;
        if ({startAttack, envState, level} !== {1'b1, 2'd1, 10'd1}) begin errors++; $display("FAIL retrig_attack got %b/%0d/%0d want 1/1/1", startAttack, envState, level); end
        repeat (SETTLE) cyc();
        incAttack = 1'b1;
        for (int n = 0; n < 30 && mPhase != 2; n++) begin
            cyc();
            checks++;
            if (dutOut !== modelOut()) begin errors++; $display("FAIL retrig_ramp got %h want %h", dutOut, modelOut()); end
        end
        incAttack = 1'b0;
        checks++;
        if (level !== 10'd6 || envState !== 2'd2) begin errors++; $display("FAIL retrig_peak got %0d/%0d want 6/2", level, envState); end
    endtask

    task automatic test_boundaries();
        gate = 1'b0;
        cyc();
        repeat (SETTLE) cyc();
        incRelease = 1'b1;
        for (int n = 0; n < 30 && mPhase != 0; n++) begin
            cyc();
            checks++;
            if (dutOut !== modelOut()) begin errors++; $display("FAIL drain got %h want %h", dutOut, modelOut()); end
        end
        incRelease = 1'b0;
        maxOut = 10'd0; gate = 1'b1;
        cyc();
        incAttack = 1'b1;
        repeat (SETTLE) cyc();
        checks++;
        if (envState !== 2'd1) begin errors++; $display("FAIL zero_max_settle got %0d want 1", envState); end
        cyc();
        incAttack = 1'b0;
        checks++;
        if (envState !== 2'd2 || level !== 10'd0) begin errors++; $display("FAIL zero_max_hold got %0d/%0d want 2/0", envState, level); end
        gate = 1'b0;
        cyc();
        repeat (SETTLE) cyc();
        cyc();
        checks++;
        if (done !== 1'b1 || envState !== 2'd0) begin errors++; $display("FAIL zero_release_done got %b/%0d want 1/0", done, envState); end
        maxOut = 10'd8; gate = 1'b1;
        cyc();
        repeat (SETTLE) cyc();
        incRelease = 1'b1;
        repeat (3) cyc();
        incRelease = 1'b0;
        checks++;
        if (level !== 10'd0 || envState !== 2'd1) begin errors++; $display("FAIL wrong_phase_inc got %0d/%0d want 0/1", level, envState); end
        incAttack = 1'b1;
        for (int n = 0; n < 30 && mPhase != 2; n++) cyc();
        incAttack = 1'b0;
        checks++;
        if (level !== 10'd8 || envState !== 2'd2) begin errors++; $display("FAIL hold8 got %0d/%0d want 8/2", level, envState); end
        maxOut = 10'd5;
        cyc();
        checks++;
        if (level !== 10'd5) begin errors++; $display("FAIL hold_track_down got %0d want 5", level); end
        maxOut = 10'd9;
        cyc();
        checks++;
        if (level !== 10'd5 || envState !== 2'd2) begin errors++; $display("FAIL hold_no_raise got %0d/%0d want 5/2", level, envState); end
    endtask

    task automatic test_reset_mid();
        gate = 1'b0;
        cyc();
        gate = 1'b1; maxOut = 10'd7;
        cyc();
        repeat (SETTLE) cyc();
        incAttack = 1'b1;
        for (int n = 0; n < 30 && mPhase != 2; n++) cyc();
        incAttack = 1'b0;
        gate = 1'b0;
        cyc();
        repeat (SETTLE) cyc();
        incRelease = 1'b1;
        cyc();
        incRelease = 1'b0;
        checks++;
        if (level !== 10'd6 || envState !== 2'd3) begin errors++; $display("FAIL mid_release got %0d/%0d want 6/3", level, envState); end
        reset = 1'b0; gate = 1'b1;
        cyc();
        checks++;
        if (dutOut !== '0) begin errors++; $display("FAIL mid_reset got %h want 0", dutOut); end
        cyc();
        reset = 1'b1;
        cyc();
        checks++;
        if ({startAttack, envState, level} !== {1'b1, 2'd1, 10'd0}) begin errors++; $display("FAIL held_gate_rise got %b/%0d/%0d want 1/1/0", startAttack, envState, level); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            reset = ($urandom_range(0, 149) == 0) ? 1'b0 : 1'b1;
            if ($urandom_range(0, 14) == 0) gate = ~gate;
            if ($urandom_range(0, 39) == 0) maxOut = 10'($urandom_range(0, 12));
            incAttack = 1'($urandom); incRelease = 1'($urandom);
            cyc();
            checks++;
            if (dutOut !== modelOut()) begin errors++; $display("FAIL random cycle %0d got %h want %h", i, dutOut, modelOut()); end
        end
    endtask

    initial begin
        test_reset();
        test_attack();
        test_release();
        test_retrigger();
        test_boundaries();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
